// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the VGA framebuffer arbiter: display timing
// constants, framebuffer geometry, the RGB332 pixel type and the arbiter
// FSM state encoding.
package vga_fb_arbiter_pkg;

  localparam logic [9:0] H_TOTAL  = 10'd800;
  localparam logic [9:0] V_TOTAL  = 10'd525;
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;

  localparam int FB_W = 160;
  localparam int FB_H = 120;

  // {r[2:0], g[2:0], b[1:0]}
  typedef logic [7:0] rgb332_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fsm_t;

endpackage

// File: rtl/vga_fb_arbiter_addr_gen.sv
// fb_addr_gen: combinational framebuffer coordinate to linear address.
// addr = y*160 + x, built as (y<<7) + (y<<5) + x so no multiplier is needed.
// Ports:
//   i_x    in  8   framebuffer column (0..159)
//   i_y    in  7   framebuffer row    (0..119)
//   o_addr out 15  linear RAM address
module fb_addr_gen (
  input  logic [7:0]  i_x,
  input  logic [6:0]  i_y,
  output logic [14:0] o_addr
);

  logic [14:0] w_y_ext;
  logic [14:0] w_x_ext;

  assign w_y_ext = {8'd0, i_y};
  assign w_x_ext = {7'd0, i_x};
  assign o_addr  = (w_y_ext << 7) + (w_y_ext << 5) + w_x_ext;

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous-read framebuffer RAM
// (160x120 RGB332) between VGA scan-out, a clear-screen sequencer and a
// pixel writer. Scan-out prefetches each framebuffer pixel two clocks ahead
// of the beam and always owns the RAM on its slots; the sequencer and the
// writer (in that priority order) use the remaining cycles.
// Ports:
//   vgaclk, rst           pixel clock, synchronous active-high reset
//   hc, vc                beam counters from the timing generator
//   color_out             RGB332 colour for pixel (hc,vc), 0 in blanking
//   mem_addr/we/wdata     RAM command (combinational, this cycle)
//   mem_rdata             RAM read data, valid one clock after address
//   wr_req/x/y/color      writer request, held until wr_ack
//   wr_ack, wr_drop       request consumed / consumed without write
//   clr_req, clr_color    start full-screen fill with clr_color
//   clr_busy, clr_done    fill in progress / single pulse on completion
//   vblank_pulse          single pulse at hc==0, vc==480
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int SCALE_SH = 2,
  parameter int ADDR_W   = 15
) (
  input  logic              vgaclk,
  input  logic              rst,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  output logic [7:0]        color_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              wr_req,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [7:0]        wr_color,
  output logic              wr_ack,
  output logic              wr_drop,
  input  logic              clr_req,
  input  logic [7:0]        clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              vblank_pulse
);

  localparam logic [7:0]        L_FB_W = 8'(FB_W);
  localparam logic [6:0]        L_FB_H = 7'(FB_H);
  localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(FB_W * FB_H - 1);

  fsm_t              r_state;
  fsm_t              w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  rgb332_t           r_clr_color;
  logic              r_clr_done;
  logic [ADDR_W-1:0] r_addr_last;
  logic              r_rd_pend_p1;
  rgb332_t           r_pix_p2;

  logic [9:0]        w_hn;
  logic [9:0]        w_vn;
  logic              w_slot;
  logic [7:0]        w_gx;
  logic [6:0]        w_gy;
  logic [14:0]       w_gen_addr;
  logic              w_wr_in_range;
  logic              w_clr_start;
  logic              w_clr_wr;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  rgb332_t           w_wdata;
  logic              w_wr_ack;
  logic              w_wr_drop;

  // Beam position two clocks ahead; crossing the line end moves to the
  // next line, and the last line wraps to line 0.
  always_comb begin
    if (hc >= H_TOTAL - 10'd2) begin
      w_hn = hc - (H_TOTAL - 10'd2);
      w_vn = (vc == V_TOTAL - 10'd1) ? 10'd0 : vc + 10'd1;
    end else begin
      w_hn = hc + 10'd2;
      w_vn = vc;
    end
  end

  // One RAM read per framebuffer pixel: every 4th lookahead column.
  assign w_slot = (w_hn < H_ACTIVE) && (w_vn < V_ACTIVE) && (w_hn[1:0] == 2'b00);

  // The address generator is shared: scan-out owns it on display slots,
  // the writer on every other cycle.
  assign w_gx = w_slot ? 8'(w_hn >> SCALE_SH) : wr_x;
  assign w_gy = w_slot ? 7'(w_vn >> SCALE_SH) : wr_y;

  fb_addr_gen u_addr_gen (
    .i_x    (w_gx),
    .i_y    (w_gy),
    .o_addr (w_gen_addr)
  );

  assign w_wr_in_range = (wr_x < L_FB_W) && (wr_y < L_FB_H);
  assign w_clr_start   = !rst && (r_state == IDLE) && clr_req;

  // RAM command mux and FSM next state. A clear request in IDLE blocks the
  // writer for that cycle so the fill starts before any pending write.
  always_comb begin
    w_state_nxt = r_state;
    w_addr      = r_addr_last;
    w_we        = 1'b0;
    w_wdata     = wr_color;
    w_wr_ack    = 1'b0;
    w_wr_drop   = 1'b0;
    w_clr_wr    = 1'b0;
    if (!rst) begin
      if (w_clr_start) begin
        w_state_nxt = CLEAR;
      end
      if (w_slot) begin
        w_addr = ADDR_W'(w_gen_addr);
      end else if (r_state == CLEAR) begin
        w_we     = 1'b1;
        w_addr   = r_cnt;
        w_wdata  = r_clr_color;
        w_clr_wr = 1'b1;
        if (r_cnt == L_LAST) begin
          w_state_nxt = IDLE;
        end
      end else if (!clr_req && wr_req) begin
        w_wr_ack = 1'b1;
        if (w_wr_in_range) begin
          w_we    = 1'b1;
          w_addr  = ADDR_W'(w_gen_addr);
          w_wdata = wr_color;
        end else begin
          w_wr_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= w_clr_wr && (r_cnt == L_LAST);
      if (w_clr_start) begin
        r_cnt <= '0;
      end else if (w_clr_wr) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Fill colour and idle address hold are data; they need no reset.
  always_ff @(posedge vgaclk) begin
    if (w_clr_start) begin
      r_clr_color <= clr_color;
    end
    r_addr_last <= w_addr;
  end

  // p1: read issued last cycle, RAM data arrives on mem_rdata
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_rd_pend_p1 <= 1'b0;
    end else begin
      r_rd_pend_p1 <= w_slot;
    end
  end

  // p2: pixel held for its four display columns
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_pix_p2 <= '0;
    end else if (r_rd_pend_p1) begin
      r_pix_p2 <= mem_rdata;
    end
  end

  assign color_out    = ((hc < H_ACTIVE) && (vc < V_ACTIVE)) ? r_pix_p2 : 8'h00;
  assign mem_addr     = w_addr;
  assign mem_we       = w_we;
  assign mem_wdata    = w_wdata;
  assign wr_ack       = w_wr_ack;
  assign wr_drop      = w_wr_drop;
  assign clr_busy     = (r_state == CLEAR);
  assign clr_done     = r_clr_done;
  assign vblank_pulse = !rst && (hc == 10'd0) && (vc == V_ACTIVE);

endmodule
